// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: store-buffer drains and load-miss reads, one transaction at a time, with fence.
// Optional store anti-starvation counter enabled by defining DMEM_STORE_STARVE_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sb_valid,
  input  logic [ADDR_W-1:0]   sb_addr,
  input  logic [DATA_W-1:0]   sb_data,
  input  logic [DATA_W/8-1:0] sb_be,
  input  logic                sb_full,
  output logic                sb_ready,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_ready,
  output logic                ld_resp_valid,
  output logic [DATA_W-1:0]   ld_resp_data,
  input  logic                fence_req,
  output logic                fence_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t state, state_nxt;
  logic   fence_pending;
  logic   grant_st, grant_ld, take_resp, done_cond, starve;

`ifdef DMEM_STORE_STARVE_EN
  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CW-1:0] starve_cnt;

  assign starve = (starve_cnt >= CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_st || !sb_valid)
      starve_cnt <= '0;
    else if (grant_ld && starve_cnt != '1)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // No counter: the limit can never be reached.
  assign starve = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_st  = 1'b0;
    grant_ld  = 1'b0;
    take_resp = 1'b0;
    case (state)
      IDLE: begin
        // Starvation promotes the plain store rule ahead of loads.
        if (sb_valid && (fence_pending || sb_full || starve))
          grant_st = 1'b1;
        else if (ld_req && !fence_pending)
          grant_ld = 1'b1;
        else if (sb_valid)
          grant_st = 1'b1;
        if (grant_st || grant_ld)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (mem_we) begin
            state_nxt = IDLE;
          end else if (mem_rvalid) begin
            take_resp = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          take_resp = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sb_ready  = grant_st;
  assign ld_ready  = grant_ld;
  assign mem_req   = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done_cond = fence_pending && (state == IDLE) && !sb_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fence_pending <= 1'b0;
      fence_done    <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
    end else begin
      fence_done    <= done_cond;
      ld_resp_valid <= take_resp;
      if (take_resp)
        ld_resp_data <= mem_rdata;
      if (done_cond)
        fence_pending <= 1'b0;
      else if (fence_req && !fence_done)
        fence_pending <= 1'b1;
      if (grant_st) begin
        mem_we    <= 1'b1;
        mem_addr  <= sb_addr;
        mem_wdata <= sb_data;
        mem_be    <= sb_be;
      end else if (grant_ld) begin
        mem_we    <= 1'b0;
        mem_addr  <= ld_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
    end
  end

endmodule
